// File: rtl/fully_registered_ring_pkg.sv
// Shared types for the registered ring buffer: handshake operation encoding
// used to drive the fill-level update.
package fully_registered_ring_pkg;

    typedef enum logic [1:0] {
        HS_IDLE = 2'b00,
        HS_WR   = 2'b01,
        HS_RD   = 2'b10,
        HS_BOTH = 2'b11
    } hs_op_e;

    function automatic hs_op_e hs_op(input logic wr, input logic rd);
        return hs_op_e'({rd, wr});
    endfunction

endpackage

// File: rtl/hs_wrap_ptr.sv
// Ring pointer with explicit MAX->0 wrap, so non-power-of-2 depths work.
// clr has priority over inc.
module hs_wrap_ptr #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         s_rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == W'(MAX)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fully_registered_ring.sv
// SLOTS-entry circular register buffer between valid/ready interfaces; every
// handshake output is derived from flops only, never from dst_ready.
module fully_registered_ring
    import fully_registered_ring_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int SLOTS     = 4,
    parameter  int AFULL_LVL = SLOTS - 1,
    localparam int LVL_W     = $clog2(SLOTS + 1),
    localparam int PTR_W     = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data,
    input  logic             dst_ready,
    output logic [LVL_W-1:0] level,
    output logic             almost_full
);

    // Handshake contract: a word moves on an edge where valid & ready are both
    // high; ready never looks at the partner's valid in the same cycle.

    logic [SLOTS-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [SLOTS];
    logic [LVL_W-1:0] level_q, level_d;
    logic             afull_q, afull_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_en, rd_en;
    hs_op_e           op;

    assign src_ready = ~&valid_q;
    assign dst_valid = |valid_q;
    assign dst_data  = data_q[rd_ptr];
    assign level       = level_q;
    assign almost_full = afull_q;

    assign wr_en = src_valid & src_ready;
    assign rd_en = dst_valid & dst_ready;
    assign op    = hs_op(wr_en, rd_en);

    hs_wrap_ptr #(.MAX(SLOTS - 1), .W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .s_rst (s_rst),
        .clr_i (flush),
        .inc_i (wr_en),
        .ptr_o (wr_ptr)
    );

    hs_wrap_ptr #(.MAX(SLOTS - 1), .W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .s_rst (s_rst),
        .clr_i (flush),
        .inc_i (rd_en),
        .ptr_o (rd_ptr)
    );

    // Pointers only coincide when empty or full, so the set and clear never collide.
    always_comb begin
        valid_d = valid_q;
        level_d = level_q;
        if (flush) begin
            valid_d = '0;
            level_d = '0;
        end else begin
            if (wr_en) valid_d[wr_ptr] = 1'b1;
            if (rd_en) valid_d[rd_ptr] = 1'b0;
            case (op)
                HS_WR:   level_d = level_q + 1'b1;
                HS_RD:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        afull_d = (level_d >= LVL_W'(AFULL_LVL));
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            valid_q <= '0;
            level_q <= '0;
            afull_q <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            level_q <= level_d;
            afull_q <= afull_d;
            if (wr_en && !flush) begin
                data_q[wr_ptr] <= src_data;
            end
        end
    end

endmodule

// File: tb/tb_fully_registered_ring.sv
// Directed bench for fully_registered_ring: a 4-slot and a 3-slot instance
// share inputs; the 3-slot one also gets a randomized queue-model phase.
module tb_fully_registered_ring;

    logic       clk = 1'b0;
    logic       s_rst = 1'b1;
    logic       flush = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       dst_ready = 1'b0;

    logic       s4_ready, d4_valid, af4;
    logic [7:0] d4_data;
    logic [2:0] lvl4;
    logic       s3_ready, d3_valid, af3;
    logic [7:0] d3_data;
    logic [1:0] lvl3;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pat [4];

    always #5 clk = ~clk;

    fully_registered_ring #(.WIDTH(8), .SLOTS(4)) dut4 (
        .clk(clk), .s_rst(s_rst), .flush(flush),
        .src_valid(src_valid), .src_data(src_data), .src_ready(s4_ready),
        .dst_valid(d4_valid), .dst_data(d4_data), .dst_ready(dst_ready),
        .level(lvl4), .almost_full(af4)
    );

    fully_registered_ring #(.WIDTH(8), .SLOTS(3)) dut3 (
        .clk(clk), .s_rst(s_rst), .flush(flush),
        .src_valid(src_valid), .src_data(src_data), .src_ready(s3_ready),
        .dst_valid(d3_valid), .dst_data(d3_data), .dst_ready(dst_ready),
        .level(lvl3), .almost_full(af3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       hold;
        logic       wr, rd;
        logic       r0;
        logic [7:0] nd;

        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        // Reset and idle
        step(); step();
        s_rst = 1'b0;
        step();
        chk("rst_src_ready", s4_ready, 1);
        chk("rst_dst_valid", d4_valid, 0);
        chk("rst_level", lvl4, 0);
        chk("rst_afull", af4, 0);
        chk("rst_dst_data", d4_data, 8'h00);

        // Fill the 4-slot ring with the sink stalled
        src_valid = 1'b1;
        dst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_data = pat[i];
            step();
            chk("fill_level", lvl4, i + 1);
            chk("fill_afull", af4, (i >= 2) ? 1 : 0);
            chk("fill_head", d4_data, 8'h11);
        end
        chk("full_src_ready", s4_ready, 0);
        src_data = 8'h55;
        step();
        chk("full_hold_level", lvl4, 4);
        chk("full_hold_head", d4_data, 8'h11);

        // Drain in order
        src_valid = 1'b0;
        dst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", d4_data, pat[i]);
            chk("drain_valid", d4_valid, 1);
            step();
        end
        chk("drained_valid", d4_valid, 0);
        chk("drained_level", lvl4, 0);
        chk("drained_afull", af4, 0);
        chk("drained_src_ready", s4_ready, 1);

        // Steady stream on both depths; the 3-slot ring wraps repeatedly
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        src_valid = 1'b1;
        dst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            src_data = 8'(i);
            step();
            chk("stream4_level", lvl4, 1);
            chk("stream4_data", d4_data, i);
            chk("stream3_level", lvl3, 1);
            chk("stream3_data", d3_data, i);
        end
        src_valid = 1'b0;
        step();
        chk("stream4_empty", d4_valid, 0);
        chk("stream3_empty", d3_valid, 0);

        // Flush at level 2 with concurrent write and read
        dst_ready = 1'b0;
        src_valid = 1'b1;
        src_data = 8'h01;
        step();
        src_data = 8'h02;
        step();
        chk("pre_flush_level", lvl4, 2);
        flush = 1'b1;
        src_data = 8'hAA;
        dst_ready = 1'b1;
        step();
        chk("flush_level", lvl4, 0);
        chk("flush_dst_valid", d4_valid, 0);
        chk("flush_afull", af4, 0);
        chk("flush_src_ready", s4_ready, 1);
        flush = 1'b0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        step();
        chk("post_flush_valid", d4_valid, 0);
        src_valid = 1'b1;
        src_data = 8'h5A;
        step();
        chk("post_flush_level", lvl4, 1);
        chk("post_flush_data", d4_data, 8'h5A);

        // Reset mid-stream wipes contents including slot data
        src_valid = 1'b0;
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        chk("midrst_level", lvl4, 0);
        chk("midrst_valid", d4_valid, 0);
        chk("midrst_data", d4_data, 8'h00);

        // Randomized traffic on the 3-slot ring against a queue model
        hold = 1'b0;
        nd = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            if (!hold) begin
                src_valid = 1'($urandom_range(0, 1));
                nd = 8'($urandom_range(0, 255));
            end
            src_data = nd;
            dst_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_src_ready", s3_ready, (exp_q.size() < 3) ? 1 : 0);
            chk("rnd_dst_valid", d3_valid, (exp_q.size() > 0) ? 1 : 0);
            chk("rnd_level", lvl3, exp_q.size());
            chk("rnd_afull", af3, (exp_q.size() >= 2) ? 1 : 0);
            if (exp_q.size() > 0) chk("rnd_data", d3_data, exp_q[0]);
            if (n % 50 == 0) begin
                r0 = s3_ready;
                dst_ready = ~dst_ready;
                #1;
                chk("rnd_no_comb_path", s3_ready, r0);
                dst_ready = ~dst_ready;
            end
            wr = src_valid && (exp_q.size() < 3);
            rd = dst_ready && (exp_q.size() > 0);
            hold = src_valid && !wr;
            step();
            if (rd) void'(exp_q.pop_front());
            if (wr) exp_q.push_back(nd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
